// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select lines of a shared 8:1 mux.
// Grants are held until the owner drops its request or HOLD_MAX cycles pass.
module mux_rr_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic       S0,
  output logic       S1,
  output logic       S2,
  output logic [7:0] gnt,
  output logic       active
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state, state_n;
  logic [2:0]  ptr, ptr_n;
  logic [2:0]  owner, owner_n;
  logic [3:0]  cnt, cnt_n;
  logic [2:0]  sel, sel_n;
  logic [7:0]  gnt_n;
  logic        active_n;
  logic        found;
  logic [2:0]  pick;
  logic        release_now;

  // Scan from the far end back toward ptr so the last hit is the nearest one.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    for (int i = 7; i >= 0; i--) begin
      if (req[ptr + 3'(i)]) begin
        found = 1'b1;
        pick  = ptr + 3'(i);
      end
    end
  end

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    owner_n     = owner;
    cnt_n       = cnt;
    sel_n       = sel;
    gnt_n       = gnt;
    active_n    = active;
    release_now = (req[owner] == 1'b0) || (cnt == 4'(HOLD_MAX));
    case (state)
      IDLE: begin
        if (found) begin
          state_n  = GRANT;
          owner_n  = pick;
          gnt_n    = 8'b1 << pick;
          sel_n    = pick;
          active_n = 1'b1;
          cnt_n    = 4'd1;
          ptr_n    = pick + 3'd1;
        end
      end
      GRANT: begin
        if (!release_now) begin
          cnt_n = cnt + 4'd1;
        end else if (found) begin
          owner_n  = pick;
          gnt_n    = 8'b1 << pick;
          sel_n    = pick;
          active_n = 1'b1;
          cnt_n    = 4'd1;
          ptr_n    = pick + 3'd1;
        end else begin
          // Select lines keep the last owner so the mux output stays stable.
          state_n  = IDLE;
          gnt_n    = 8'h00;
          active_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= 3'd0;
      owner  <= 3'd0;
      cnt    <= 4'd0;
      sel    <= 3'd0;
      gnt    <= 8'h00;
      active <= 1'b0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      owner  <= owner_n;
      cnt    <= cnt_n;
      sel    <= sel_n;
      gnt    <= gnt_n;
      active <= active_n;
    end
  end

  assign S0 = sel[0];
  assign S1 = sel[1];
  assign S2 = sel[2];

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios plus random
// traffic compared every cycle against a behavioural model.
module tb_mux_rr_arbiter;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       S0, S1, S2;
  logic [7:0] gnt;
  logic       active;

  int testCount = 0;
  int failCount = 0;

  // Behavioural model state: owner index or -1 when idle
  int         mOwner = -1;
  int         mPtr = 0;
  int         mCnt = 0;
  int         mSel = 0;
  logic [7:0] mGnt = 8'h00;
  logic       mActive = 1'b0;

  mux_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst(rst), .req(req),
    .S0(S0), .S1(S1), .S2(S2),
    .gnt(gnt), .active(active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pickIdx(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic modelGrant(input int p);
    mOwner  = p;
    mCnt    = 1;
    mPtr    = (p + 1) % 8;
    mGnt    = 8'h00;
    mGnt[p] = 1'b1;
    mSel    = p;
    mActive = 1'b1;
  endtask

  task automatic modelStep(input logic r, input logic [7:0] q);
    int p;
    if (r) begin
      mOwner = -1; mPtr = 0; mCnt = 0; mSel = 0; mGnt = 8'h00; mActive = 1'b0;
    end else if (mOwner < 0) begin
      p = pickIdx(q, mPtr);
      if (p >= 0) modelGrant(p);
    end else if (q[mOwner] && mCnt < HOLD) begin
      mCnt++;
    end else begin
      p = pickIdx(q, mPtr);
      if (p >= 0) modelGrant(p);
      else begin
        mOwner = -1; mGnt = 8'h00; mActive = 1'b0;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [7:0] q);
    rst = r;
    req = q;
    modelStep(r, q);
    @(posedge clk);
    #1;
    checkOutput("gnt", 32'(gnt), 32'(mGnt));
    checkOutput("sel", 32'({S2, S1, S0}), 32'(mSel));
    checkOutput("active", 32'(active), 32'(mActive));
  endtask

  initial begin
    logic [7:0] q;
    rst = 1'b1;
    req = 8'h00;

    // Reset with full request, then first grant searches from index 0
    applyStimulus(1'b1, 8'hFF);
    applyStimulus(1'b1, 8'hFF);
    checkOutput("reset_gnt", 32'(gnt), 32'h00);
    checkOutput("reset_active", 32'(active), 32'h0);
    applyStimulus(1'b0, 8'hFF);
    checkOutput("first_gnt", 32'(gnt), 32'h01);

    // Full contention: each requester in turn, 4 cycles apiece
    for (int i = 0; i < 8 * HOLD + 4; i++) begin
      applyStimulus(1'b0, 8'hFF);
      checkOutput("contend_active", 32'(active), 32'h1);
    end

    // Sole requester keeps the grant across expiry
    applyStimulus(1'b1, 8'h00);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 8'h20);
      checkOutput("sole_gnt", 32'(gnt), 32'h20);
    end

    // Early release leaves select lines at the last owner
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b0, 8'h04);
    applyStimulus(1'b0, 8'h04);
    applyStimulus(1'b0, 8'h00);
    checkOutput("early_sel", 32'({S2, S1, S0}), 32'h2);
    checkOutput("early_active", 32'(active), 32'h0);

    // Wrap priority: grant 6 leaves ptr at 7
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b0, 8'h40);
    applyStimulus(1'b0, 8'h82);
    checkOutput("wrap_gnt7", 32'(gnt), 32'h80);
    applyStimulus(1'b0, 8'h02);
    checkOutput("wrap_gnt1", 32'(gnt), 32'h02);

    // Reset during a grant to 5; restart favours 0
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b0, 8'h20);
    applyStimulus(1'b0, 8'h21);
    applyStimulus(1'b1, 8'h21);
    applyStimulus(1'b0, 8'h21);
    checkOutput("midrst_gnt", 32'(gnt), 32'h01);

    // Random traffic with occasional resets and held request patterns
    q = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 5))
        0:       q = 8'h00;
        1:       q = 8'($urandom);
        2:       q = 8'h01 << $urandom_range(0, 7);
        3:       q = q ^ (8'h01 << $urandom_range(0, 7));
        default: q = q;
      endcase
      applyStimulus($urandom_range(0, 99) == 0, q);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
